timer_ctrl: RTL and testbench

//  Control FSM driving the microwave BCD down-counter chain (4 x mod-10/mod-6 digits, MM:SS).

---
 rtl/timer_pkg.sv | 17 +
 rtl/timer_ctrl_if.sv | 29 ++
 rtl/timer_ctrl_tick_gen.sv | 29 ++
 rtl/timer_ctrl.sv | 142 ++++++++++++++
 tb/tb_timer_ctrl.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the microwave timer controller.
package timer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    PAUSE,
    DONE
  } state_e;

  typedef logic [3:0] bcd_t;

  localparam bcd_t        BCD_MAX = 4'd9;
  localparam int unsigned ENTRY_W = 16;

endpackage

// File: rtl/timer_ctrl_if.sv
// Keypad, door, counter-chain and status signals between the timer controller and its surroundings.
interface timer_ctrl_if;
  import timer_pkg::*;

  logic               key_valid;
  bcd_t               key_digit;
  logic               startn;
  logic               stopn;
  logic               door_closed;
  logic               zero_all;
  logic [ENTRY_W-1:0] load_data;
  logic               loadn;
  logic               en;
  logic               cnt_clearn;
  logic               magnetron_on;
  logic               done;
  logic               beep;

  modport master (
    output key_valid, key_digit, startn, stopn, door_closed, zero_all,
    input  load_data, loadn, en, cnt_clearn, magnetron_on, done, beep
  );

  modport slave (
    input  key_valid, key_digit, startn, stopn, door_closed, zero_all,
    output load_data, loadn, en, cnt_clearn, magnetron_on, done, beep
  );

endinterface

// File: rtl/timer_ctrl_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV running cycles; holds its count while not running.
module tick_gen #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clock,
  input  logic clearn,
  input  logic i_run,
  input  logic i_clear,
  output logic o_tick_c
);

  localparam int unsigned      CNT_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_tick_c = i_run && (r_cnt == CNT_MAX);

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_run) begin
      r_cnt <= o_tick_c ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Microwave timer control FSM: keypad entry, counter load, 1 Hz count enables, done handling.
// Optional done-beep is compiled in with `define TIMER_BEEP_EN.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter int unsigned BEEP_SECS = 3
) (
  input logic         clock,
  input logic         clearn,
  timer_ctrl_if.slave bus
);

  if (TICK_DIV < 2 || BEEP_SECS < 1) begin : g_bad_params
    $error("timer_ctrl: TICK_DIV must be >= 2 and BEEP_SECS >= 1");
  end

  state_e             r_state, w_state_nxt;
  logic [ENTRY_W-1:0] r_entry, w_entry_nxt;
  logic               r_loadn, r_en, r_cnt_clearn, r_mag, r_done;
  logic               w_loadn_nxt, w_en_nxt, w_cnt_clr, w_mag_nxt, w_done_nxt;
  logic               w_pre_run, w_pre_clear, w_tick;
  logic               w_start, w_stop, w_door_open;

  assign w_start     = ~bus.startn;
  assign w_stop      = ~bus.stopn;
  assign w_door_open = ~bus.door_closed;

  // Next state and next registered output values.
  always_comb begin
    w_state_nxt = r_state;
    w_entry_nxt = r_entry;
    w_cnt_clr   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_stop && w_start && bus.door_closed && (r_entry != '0)) begin
          w_state_nxt = LOAD;
        end else if (bus.key_valid && (bus.key_digit <= BCD_MAX)) begin
          w_entry_nxt = {r_entry[ENTRY_W-5:0], bus.key_digit};
        end
      end
      LOAD: w_state_nxt = RUN;
      RUN: begin
        if (w_door_open || w_stop) w_state_nxt = PAUSE;
        else if (bus.zero_all)     w_state_nxt = DONE;
      end
      PAUSE: begin
        if (w_stop) begin
          w_state_nxt = IDLE;
          w_entry_nxt = '0;
          w_cnt_clr   = 1'b1;
        end else if (w_start && bus.door_closed) begin
          w_state_nxt = RUN;
        end
      end
      DONE: begin
        if (w_door_open || w_stop || w_start) begin
          w_state_nxt = IDLE;
          w_entry_nxt = '0;
          w_cnt_clr   = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Prescaler freezes on the cycle RUN is left so a paused tick is not lost.
    w_pre_run   = (r_state == RUN) && (w_state_nxt == RUN);
`ifdef TIMER_BEEP_EN
    w_pre_run   = w_pre_run || (r_state == DONE);
`endif
    w_pre_clear = (w_state_nxt == LOAD) || ((r_state != DONE) && (w_state_nxt == DONE));

    w_loadn_nxt = (w_state_nxt != LOAD);
    w_en_nxt    = w_tick && (r_state == RUN);
    w_mag_nxt   = (w_state_nxt == RUN);
    w_done_nxt  = (w_state_nxt == DONE);
  end

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      r_state      <= IDLE;
      r_entry      <= '0;
      r_loadn      <= 1'b1;
      r_en         <= 1'b0;
      r_cnt_clearn <= 1'b0;
      r_mag        <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_entry      <= w_entry_nxt;
      r_loadn      <= w_loadn_nxt;
      r_en         <= w_en_nxt;
      r_cnt_clearn <= ~w_cnt_clr;
      r_mag        <= w_mag_nxt;
      r_done       <= w_done_nxt;
    end
  end

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clock    (clock),
    .clearn   (clearn),
    .i_run    (w_pre_run),
    .i_clear  (w_pre_clear),
    .o_tick_c (w_tick)
  );

`ifdef TIMER_BEEP_EN
  localparam int unsigned      BEEP_W   = $clog2(BEEP_SECS + 1);
  localparam logic [BEEP_W-1:0] BEEP_MAX = BEEP_W'(BEEP_SECS);

  logic [BEEP_W-1:0] r_beep_cnt, w_beep_cnt_nxt;
  logic              r_beep;

  assign w_beep_cnt_nxt = r_beep_cnt + BEEP_W'(w_tick && (r_beep_cnt < BEEP_MAX));

  // Beep counts whole tick periods from DONE entry; the prescaler restarts on entry.
  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      r_beep_cnt <= '0;
      r_beep     <= 1'b0;
    end else if (r_state != DONE) begin
      r_beep_cnt <= '0;
      r_beep     <= (w_state_nxt == DONE);
    end else begin
      r_beep_cnt <= w_beep_cnt_nxt;
      r_beep     <= (w_state_nxt == DONE) && (w_beep_cnt_nxt < BEEP_MAX);
    end
  end

  assign bus.beep = r_beep;
`else
  assign bus.beep = 1'b0;
`endif

  assign bus.load_data    = r_entry;
  assign bus.loadn        = r_loadn;
  assign bus.en           = r_en;
  assign bus.cnt_clearn   = r_cnt_clearn;
  assign bus.magnetron_on = r_mag;
  assign bus.done         = r_done;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed scoreboard bench for timer_ctrl with TICK_DIV=4, BEEP_SECS=2.
module tb_timer_ctrl;
  import timer_pkg::*;

  localparam int unsigned TICK_DIV  = 4;
  localparam int unsigned BEEP_SECS = 2;
`ifdef TIMER_BEEP_EN
  localparam logic BEEP_ON = 1'b1;
`else
  localparam logic BEEP_ON = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic [20:0] exp;
  } exp_t;

  logic clock  = 1'b0;
  logic clearn = 1'b0;
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  timer_ctrl_if bus ();

  timer_ctrl #(.TICK_DIV(TICK_DIV), .BEEP_SECS(BEEP_SECS)) dut (
    .clock  (clock),
    .clearn (clearn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  // {load_data, loadn, en, cnt_clearn, magnetron_on, done, beep}
  function automatic logic [20:0] mk(input logic [15:0] ld, input logic loadn, input logic en,
                                     input logic cc, input logic mag, input logic dn,
                                     input logic bp);
    return {ld, loadn, en, cc, mag, dn, bp};
  endfunction

  function automatic logic [20:0] idle_v(input logic [15:0] ld);
    return mk(ld, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [20:0] run_v(input logic [15:0] ld, input logic en);
    return mk(ld, 1'b1, en, 1'b1, 1'b1, 1'b0, 1'b0);
  endfunction

  function automatic logic [20:0] obs();
    return {bus.load_data, bus.loadn, bus.en, bus.cnt_clearn, bus.magnetron_on, bus.done, bus.beep};
  endfunction

  task automatic check_out();
    exp_t        x;
    logic [20:0] o;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      o = obs();
      n_checks++;
      assert (o === x.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", x.tag, o, x.exp);
      end
    end
  endtask

  task automatic now(input string tag, input logic [20:0] e);
    sb.push_back('{tag: tag, exp: e});
    check_out();
  endtask

  task automatic cyc(input string tag, input logic [20:0] e);
    sb.push_back('{tag: tag, exp: e});
    @(posedge clock);
    #1;
    bus.key_valid = 1'b0;
    bus.startn    = 1'b1;
    bus.stopn     = 1'b1;
    check_out();
  endtask

  task automatic key(input bcd_t d, input logic [15:0] ld_exp);
    bus.key_valid = 1'b1;
    bus.key_digit = d;
    cyc($sformatf("key_%h", d), idle_v(ld_exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] ld_seq [4];
    ld_seq = '{16'h0001, 16'h0012, 16'h0123, 16'h1234};

    bus.key_valid   = 1'b0;
    bus.key_digit   = 4'd0;
    bus.startn      = 1'b1;
    bus.stopn       = 1'b1;
    bus.door_closed = 1'b1;
    bus.zero_all    = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    now("reset", mk(16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    clearn = 1'b1;
    cyc("reset_release", idle_v(16'h0));

    // Empty entry: start ignored, invalid digit ignored.
    bus.startn = 1'b0;
    cyc("start_empty", idle_v(16'h0));
    key(4'hA, 16'h0);

    for (int i = 0; i < 4; i++) key(bcd_t'(i + 1), ld_seq[i]);

    bus.door_closed = 1'b0;
    bus.startn      = 1'b0;
    cyc("start_door_open", idle_v(16'h1234));
    bus.door_closed = 1'b1;

    bus.startn = 1'b0;
    cyc("load", mk(16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    cyc("run_entry", run_v(16'h1234, 1'b0));
    for (int i = 0; i < 8; i++) cyc($sformatf("run_%0d", i), run_v(16'h1234, (i % 4) == 3));
    cyc("run_pre_a", run_v(16'h1234, 1'b0));
    cyc("run_pre_b", run_v(16'h1234, 1'b0));

    // Door opens with two prescaler counts already taken.
    bus.door_closed = 1'b0;
    cyc("pause_door", idle_v(16'h1234));
    cyc("pause_hold_a", idle_v(16'h1234));
    cyc("pause_hold_b", idle_v(16'h1234));
    bus.door_closed = 1'b1;
    bus.startn      = 1'b0;
    cyc("resume", run_v(16'h1234, 1'b0));
    cyc("resume_1", run_v(16'h1234, 1'b0));
    cyc("resume_tick", run_v(16'h1234, 1'b1));

    bus.stopn = 1'b0;
    cyc("stop_to_pause", idle_v(16'h1234));
    bus.startn = 1'b0;
    bus.stopn  = 1'b0;
    cyc("start_stop_cancel", mk(16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc("cancel_release", idle_v(16'h0));

    // Zero reached on the same cycle as a tick.
    key(4'd0, 16'h0000);
    key(4'd5, 16'h0005);
    bus.startn = 1'b0;
    cyc("load2", mk(16'h0005, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    cyc("run2_entry", run_v(16'h0005, 1'b0));
    for (int i = 0; i < 3; i++) cyc($sformatf("run2_%0d", i), run_v(16'h0005, 1'b0));
    bus.zero_all = 1'b1;
    cyc("zero_at_tick", mk(16'h0005, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, BEEP_ON));
    for (int k = 1; k <= 9; k++)
      cyc($sformatf("done_%0d", k), mk(16'h0005, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, BEEP_ON && (k < 8)));
    bus.startn   = 1'b0;
    bus.zero_all = 1'b0;
    cyc("done_exit", mk(16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc("done_exit_release", idle_v(16'h0));

    // Asynchronous reset in the middle of RUN.
    key(4'd9, 16'h0009);
    bus.startn = 1'b0;
    cyc("load3", mk(16'h0009, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    cyc("run3_entry", run_v(16'h0009, 1'b0));
    cyc("run3_0", run_v(16'h0009, 1'b0));
    #2;
    clearn = 1'b0;
    #1;
    now("async_reset", mk(16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(posedge clock);
    #1;
    now("reset_held", mk(16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    clearn = 1'b1;
    cyc("reset_release2", idle_v(16'h0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
